decoder_seq_onehot: RTL and testbench

- Parametrised successor to the fixed 2-to-4 and 5-to-32 decoders in the SimpleProcessor.
- Produces a registered one-hot select vector of 2**SEL_W lines.
- Has four modes:
  - direct decode of i_sel
  - scan up (auto-increment ring walk)
  - scan down (auto-decrement ring walk)
  - hold
- Used for register-file write selects and for sequencing peripheral/bank strobes without an external counter.

---
 rtl/decoder_pkg.sv | 12 +
 rtl/scan_tick_gen.sv | 37 +++
 rtl/decoder_seq_onehot.sv | 105 ++++++++++
 tb/tb_decoder_seq_onehot.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the sequenced one-hot decoder.
// Provides the 2-bit operating mode type and its encodings.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Scan-step prescaler: produces one tick every SCAN_DIV running edges.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous active-high reset
//   i_clr  - restart counting from zero on this edge (wins over the held count)
//   i_run  - count this edge; when low the count holds (or clears if i_clr)
//   o_tick - combinational; high on the edge that should advance the pointer
module scan_tick_gen #(
  parameter int SCAN_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_eff;

  // A clear restarts the count at zero and the same edge still counts,
  // so with SCAN_DIV = 1 a cleared edge is also a tick.
  assign cnt_eff = i_clr ? '0 : cnt;
  assign o_tick  = i_run && (cnt_eff == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       cnt <= '0;
    else if (o_tick) cnt <= '0;
    else if (i_run)  cnt <= cnt_eff + ONE;
    else             cnt <= cnt_eff;
  end

endmodule

// File: rtl/decoder_seq_onehot.sv
// Registered one-hot select generator with direct decode, ring scan up/down
// and hold modes. Used for register-file write selects and for stepping
// through bank/peripheral strobes without an external counter.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - asynchronous active-high reset
//   i_en     - enable; low freezes pointer/prescaler and blanks o_onehot
//   i_mode   - 00 decode, 01 scan up, 10 scan down, 11 hold
//   i_sel    - decode index, or pointer load value with i_load
//   i_load   - load pointer from i_sel, overrides mode and enable
//   o_onehot - registered one-hot select, zero when not valid
//   o_idx    - registered pointer
//   o_valid  - registered i_en
//   o_wrap   - one-cycle pulse when a scan step wraps the ring
module decoder_seq_onehot
  import decoder_pkg::*;
#(
  parameter int SEL_W    = 5,
  parameter int SCAN_DIV = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [1:0]            i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_load,
  output logic [(1<<SEL_W)-1:0] o_onehot,
  output logic [SEL_W-1:0]      o_idx,
  output logic                  o_valid,
  output logic                  o_wrap
);

  localparam int N_OUT = 1 << SEL_W;
  localparam logic [SEL_W-1:0] PTR_ONE = SEL_W'(1);

  mode_t            mode, prev_mode;
  logic             mode_chg, is_scan, tick_clr, tick_run, tick;
  logic [SEL_W-1:0] ptr, ptr_d;
  logic [N_OUT-1:0] onehot_d;
  logic             wrap_d;

  assign mode     = mode_t'(i_mode);
  assign mode_chg = (mode != prev_mode);
  assign is_scan  = (mode == MODE_SCAN_UP) || (mode == MODE_SCAN_DOWN);

  // Load and decode reset the prescaler; a mode change restarts it while
  // the new mode (scan or hold) decides whether this edge also counts.
  // Disabled edges neither clear nor count.
  assign tick_clr = i_load || (i_en && (mode == MODE_DECODE || mode_chg));
  assign tick_run = !i_load && i_en && is_scan;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (tick_clr),
    .i_run  (tick_run),
    .o_tick (tick)
  );

  always_comb begin
    ptr_d  = ptr;
    wrap_d = 1'b0;
    if (i_load) begin
      ptr_d = i_sel;
    end else if (i_en) begin
      case (mode)
        MODE_DECODE: ptr_d = i_sel;
        MODE_SCAN_UP: if (tick) begin
          ptr_d  = ptr + PTR_ONE;
          wrap_d = &ptr;
        end
        MODE_SCAN_DOWN: if (tick) begin
          ptr_d  = ptr - PTR_ONE;
          wrap_d = ~|ptr;
        end
        default: ;
      endcase
    end
  end

  // One-hot decode of the next pointer, gated by enable so the registered
  // vector is zero whenever o_valid is low.
  for (genvar i = 0; i < N_OUT; i++) begin : g_dec
    assign onehot_d[i] = i_en && (ptr_d == SEL_W'(i));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr       <= '0;
      o_onehot  <= '0;
      o_valid   <= 1'b0;
      o_wrap    <= 1'b0;
      prev_mode <= MODE_DECODE;
    end else begin
      ptr       <= ptr_d;
      o_onehot  <= onehot_d;
      o_valid   <= i_en;
      o_wrap    <= wrap_d;
      prev_mode <= mode;
    end
  end

  assign o_idx = ptr;

endmodule

// File: tb/tb_decoder_seq_onehot.sv
// Bench for decoder_seq_onehot: one instance with SCAN_DIV=1 and one with
// SCAN_DIV=3 share the stimulus. Expected outputs come from a behavioural
// model, are queued when inputs are driven and compared after the edge.
module tb_decoder_seq_onehot;
  import decoder_pkg::*;

  typedef struct packed {
    logic [31:0] oh;
    logic [4:0]  idx;
    logic        vld;
    logic        wrap;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, load = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  sel = '0;
  logic [31:0] oh1, oh3;
  logic [4:0]  idx1, idx3;
  logic        v1, v3, w1, w3;

  int          n_chk = 0, n_pass = 0;
  int          m_ptr[2], m_cnt[2];
  logic [1:0]  m_pmode[2];
  exp_t        q0[$], q1[$];

  always #5 clk = ~clk;

  decoder_seq_onehot #(.SEL_W(5), .SCAN_DIV(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_sel(sel), .i_load(load),
    .o_onehot(oh1), .o_idx(idx1), .o_valid(v1), .o_wrap(w1));

  decoder_seq_onehot #(.SEL_W(5), .SCAN_DIV(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_sel(sel), .i_load(load),
    .o_onehot(oh3), .o_idx(idx3), .o_valid(v3), .o_wrap(w3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model(input int d, input int div, output exp_t x);
    int c;
    x.wrap = 1'b0;
    x.vld  = en;
    if (load) begin
      m_ptr[d] = int'(sel); m_cnt[d] = 0;
    end else if (en) begin
      if (mode == MODE_DECODE) begin
        m_ptr[d] = int'(sel); m_cnt[d] = 0;
      end else if (mode == MODE_HOLD) begin
        if (mode != m_pmode[d]) m_cnt[d] = 0;
      end else begin
        c = (mode != m_pmode[d]) ? 0 : m_cnt[d];
        if (c == div - 1) begin
          m_cnt[d] = 0;
          if (mode == MODE_SCAN_UP) begin
            x.wrap = (m_ptr[d] == 31); m_ptr[d] = (m_ptr[d] + 1) % 32;
          end else begin
            x.wrap = (m_ptr[d] == 0);  m_ptr[d] = (m_ptr[d] + 31) % 32;
          end
        end else m_cnt[d] = c + 1;
      end
    end
    m_pmode[d] = mode;
    x.idx = m_ptr[d][4:0];
    x.oh  = en ? (32'h1 << m_ptr[d]) : 32'h0;
  endtask

  // Drive at the current (falling) edge, check after the next rising edge,
  // return on the following falling edge.
  task automatic step(input logic e, input logic [1:0] m, input logic l, input logic [4:0] s);
    exp_t x0, x1;
    en = e; mode = m; load = l; sel = s;
    model(0, 1, x0); q0.push_back(x0);
    model(1, 3, x1); q1.push_back(x1);
    @(posedge clk); #1;
    x0 = q0.pop_front(); x1 = q1.pop_front();
    chk("d1_onehot", oh1, x0.oh);  chk("d1_idx", idx1, x0.idx);
    chk("d1_valid", v1, x0.vld);   chk("d1_wrap", w1, x0.wrap);
    chk("d3_onehot", oh3, x1.oh);  chk("d3_idx", idx3, x1.idx);
    chk("d3_valid", v3, x1.vld);   chk("d3_wrap", w3, x1.wrap);
    @(negedge clk);
  endtask

  // Assert reset between edges and check outputs clear without a clock edge.
  task automatic pulse_rst();
    #2 rst = 1'b1;
    for (int d = 0; d < 2; d++) begin m_ptr[d] = 0; m_cnt[d] = 0; m_pmode[d] = 2'b00; end
    q0.delete(); q1.delete();
    #1;
    chk("rst_d1_onehot", oh1, 0); chk("rst_d1_idx", idx1, 0);
    chk("rst_d1_valid", v1, 0);   chk("rst_d1_wrap", w1, 0);
    chk("rst_d3_onehot", oh3, 0); chk("rst_d3_idx", idx3, 0);
    chk("rst_d3_valid", v3, 0);   chk("rst_d3_wrap", w3, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int dn_tbl[6];
    dn_tbl = '{1, 1, 0, 0, 0, 31};

    pulse_rst();

    // Direct decode
    step(1, MODE_DECODE, 0, 19);
    chk("dec19_idx", idx1, 19); chk("dec19_onehot", oh1, 32'h0008_0000); chk("dec19_valid", v1, 1);
    step(1, MODE_DECODE, 0, 0);
    chk("dec0_onehot", oh1, 32'h0000_0001);

    // Scan up across the wrap, SCAN_DIV = 1
    step(1, MODE_SCAN_UP, 1, 30);
    step(1, MODE_SCAN_UP, 0, 0); chk("up_idx31", idx1, 31); chk("up_wrap31", w1, 0);
    step(1, MODE_SCAN_UP, 0, 0); chk("up_idx0", idx1, 0);   chk("up_wrap0", w1, 1);
    chk("up_onehot0", oh1, 32'h0000_0001);
    step(1, MODE_SCAN_UP, 0, 0); chk("up_idx1", idx1, 1);   chk("up_wrap1", w1, 0);

    // Scan down with prescale, SCAN_DIV = 3
    step(1, MODE_SCAN_DOWN, 1, 1);
    for (int k = 0; k < 6; k++) begin
      step(1, MODE_SCAN_DOWN, 0, 0);
      chk("dn_idx", idx3, dn_tbl[k]);
      chk("dn_wrap", w3, (k == 5) ? 1 : 0);
    end

    // Enable gating mid-scan, prescaler count must survive
    step(1, MODE_SCAN_UP, 1, 7);
    step(1, MODE_SCAN_UP, 0, 0);
    repeat (4) begin
      step(0, MODE_SCAN_UP, 0, 0);
      chk("gate_idx", idx3, 7); chk("gate_valid", v3, 0); chk("gate_onehot", oh3, 0);
    end
    step(1, MODE_SCAN_UP, 0, 0); chk("resume_idx7", idx3, 7);
    step(1, MODE_SCAN_UP, 0, 0); chk("resume_idx8", idx3, 8);

    // Load beats a wrapping tick; hold keeps the pointer and ignores i_sel
    step(1, MODE_SCAN_UP, 1, 31);
    step(1, MODE_SCAN_UP, 1, 5); chk("prio_idx", idx1, 5); chk("prio_wrap", w1, 0);
    repeat (10) step(1, MODE_HOLD, 0, 9);
    chk("hold_idx", idx1, 5);

    // Random mix against the model
    repeat (60) begin
      step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)));
    end

    // Async reset mid-scan at ptr 12, cnt 2
    step(1, MODE_SCAN_UP, 1, 12);
    step(1, MODE_SCAN_UP, 0, 0);
    step(1, MODE_SCAN_UP, 0, 0);
    chk("pre_rst_idx", idx3, 12);
    pulse_rst();
    step(1, MODE_SCAN_UP, 0, 0); chk("post_rst_idx_a", idx3, 0);
    step(1, MODE_SCAN_UP, 0, 0); chk("post_rst_idx_b", idx3, 0);
    step(1, MODE_SCAN_UP, 0, 0); chk("post_rst_idx_c", idx3, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
